// File: rtl/dpb_led_sequencer.sv
// Fill-then-playback controller for the dual-port block RAM LED counter demo.
// Port A fills the RAM with an incrementing pattern after `start`, then
// serves host pattern patches while port B plays the words back onto the
// active-low LEDs, one word per TICK_DIV clock cycles.
//
// Optional build macro: PLAY_PINGPONG_EN -- playback bounces 0..max..0
// instead of wrapping, and frame_done marks both end addresses.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   start                       pulse: (re)start fill, then play
//   host_wr_valid/addr/data     host patch request (accepted in PLAY)
//   host_wr_ready               high in PLAY
//   ram_cea/wrea/ada/dina       RAM port A (fill writes, host writes)
//   ram_ceb/oceb/adb, ram_doutb RAM port B (playback reads)
//   led                         LED drive, active-low
//   playing                     high in PLAY
//   frame_done                  pulse when an end-of-frame word is displayed
module dpb_led_sequencer #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned TICK_DIV = 27000000,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  output logic              ram_cea,
  output logic              ram_wrea,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_ceb,
  output logic              ram_oceb,
  output logic [ADDR_W-1:0] ram_adb,
  input  logic [DATA_W-1:0] ram_doutb,
  output logic [DATA_W-1:0] led,
  output logic              playing,
  output logic              frame_done
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_PLAY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0]   play_addr_q, play_addr_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [READ_LAT-1:0] end_q, end_d;
  logic                cea_q, cea_d;
  logic [ADDR_W-1:0]   ada_q, ada_d;
  logic [DATA_W-1:0]   dina_q, dina_d;
  logic                ceb_q, ceb_d;
  logic                rd_end_q, rd_end_d;
  logic [ADDR_W-1:0]   adb_q, adb_d;
  logic [DATA_W-1:0]   led_q, led_d;
  logic                playing_q, playing_d;
  logic                frame_done_q, frame_done_d;
  logic                ready_q, ready_d;
  logic                enter_fill, issue_rd;
  logic                host_fire_c, rd_end_c;
  logic [ADDR_W-1:0]   next_addr_c;
`ifdef PLAY_PINGPONG_EN
  logic                dir_down_q, dir_down_d, next_dir_c;
  logic                first_q, first_d;
`endif

  // Address following play_addr_q, and whether play_addr_q ends a frame.
  always_comb begin
    next_addr_c = play_addr_q + ADDR_W'(1);
`ifdef PLAY_PINGPONG_EN
    next_dir_c = dir_down_q;
    if (!dir_down_q && play_addr_q == ADDR_MAX) begin
      next_addr_c = play_addr_q - ADDR_W'(1);
      next_dir_c  = 1'b1;
    end else if (dir_down_q && play_addr_q == '0) begin
      next_addr_c = ADDR_W'(1);
      next_dir_c  = 1'b0;
    end else if (dir_down_q) begin
      next_addr_c = play_addr_q - ADDR_W'(1);
    end
    // The opening display of address 0 does not close a frame.
    rd_end_c = (play_addr_q == ADDR_MAX) || (play_addr_q == '0 && !first_q);
`else
    rd_end_c = (play_addr_q == ADDR_MAX);
`endif
  end

  // Next-state and registered-output logic. Outputs are computed for the
  // state being entered so they line up with state_q.
  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    play_addr_d  = play_addr_q;
    tick_d       = tick_q;
    vld_d        = '0;
    end_d        = '0;
    cea_d        = 1'b0;
    ada_d        = '0;
    dina_d       = '0;
    ceb_d        = 1'b0;
    rd_end_d     = 1'b0;
    adb_d        = adb_q;
    led_d        = led_q;
    playing_d    = 1'b0;
    frame_done_d = 1'b0;
    ready_d      = 1'b0;
    enter_fill   = 1'b0;
    issue_rd     = 1'b0;
`ifdef PLAY_PINGPONG_EN
    dir_down_d   = dir_down_q;
    first_d      = first_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) enter_fill = 1'b1;
      end
      ST_FILL: begin
        if (fill_addr_q == ADDR_MAX) begin
          state_d   = ST_PLAY;
          tick_d    = '0;
          playing_d = 1'b1;
          ready_d   = 1'b1;
          issue_rd  = 1'b1;
        end else begin
          fill_addr_d = fill_addr_q + ADDR_W'(1);
          cea_d       = 1'b1;
          ada_d       = fill_addr_d;
          dina_d      = DATA_W'(fill_addr_d);
        end
      end
      ST_PLAY: begin
        if (start) begin
          // Restart drops in-flight reads; led keeps its last word.
          enter_fill = 1'b1;
        end else begin
          playing_d = 1'b1;
          ready_d   = 1'b1;
          vld_d[0]  = ceb_q;
          end_d[0]  = rd_end_q;
          for (int i = 1; i < int'(READ_LAT); i++) begin
            vld_d[i] = vld_q[i-1];
            end_d[i] = end_q[i-1];
          end
          if (vld_q[READ_LAT-1]) begin
            led_d        = ~ram_doutb;
            frame_done_d = end_q[READ_LAT-1];
          end
          if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            issue_rd = 1'b1;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Begin a fresh fill: first write of address 0 goes out next cycle.
    if (enter_fill) begin
      state_d     = ST_FILL;
      fill_addr_d = '0;
      play_addr_d = '0;
      tick_d      = '0;
      cea_d       = 1'b1;
      ada_d       = '0;
      dina_d      = '0;
`ifdef PLAY_PINGPONG_EN
      dir_down_d  = 1'b0;
      first_d     = 1'b1;
`endif
    end

    // One-cycle port B read strobe for the current play address.
    if (issue_rd) begin
      ceb_d       = 1'b1;
      adb_d       = play_addr_q;
      rd_end_d    = rd_end_c;
      play_addr_d = next_addr_c;
`ifdef PLAY_PINGPONG_EN
      dir_down_d  = next_dir_c;
      first_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      fill_addr_q  <= '0;
      play_addr_q  <= '0;
      tick_q       <= '0;
      vld_q        <= '0;
      end_q        <= '0;
      cea_q        <= 1'b0;
      ada_q        <= '0;
      dina_q       <= '0;
      ceb_q        <= 1'b0;
      rd_end_q     <= 1'b0;
      adb_q        <= '0;
      led_q        <= '1;
      playing_q    <= 1'b0;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b0;
`ifdef PLAY_PINGPONG_EN
      dir_down_q   <= 1'b0;
      first_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      play_addr_q  <= play_addr_d;
      tick_q       <= tick_d;
      vld_q        <= vld_d;
      end_q        <= end_d;
      cea_q        <= cea_d;
      ada_q        <= ada_d;
      dina_q       <= dina_d;
      ceb_q        <= ceb_d;
      rd_end_q     <= rd_end_d;
      adb_q        <= adb_d;
      led_q        <= led_d;
      playing_q    <= playing_d;
      frame_done_q <= frame_done_d;
      ready_q      <= ready_d;
`ifdef PLAY_PINGPONG_EN
      dir_down_q   <= dir_down_d;
      first_q      <= first_d;
`endif
    end
  end

  // Host writes reach port A in the handshake cycle itself.
  assign host_fire_c   = host_wr_valid & ready_q;
  assign host_wr_ready = ready_q;
  assign ram_cea       = cea_q | host_fire_c;
  assign ram_wrea      = cea_q | host_fire_c;
  assign ram_ada       = host_fire_c ? host_wr_addr : ada_q;
  assign ram_dina      = host_fire_c ? host_wr_data : dina_q;
  assign ram_ceb       = ceb_q;
  assign ram_oceb      = 1'b1;
  assign ram_adb       = adb_q;
  assign led           = led_q;
  assign playing       = playing_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_dpb_led_sequencer.sv
`timescale 1ns/1ps
module tb_dpb_led_sequencer;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 6;
  localparam int          TD    = 8;
  localparam int          DEPTH = 1 << AW;
  localparam int          AMAX  = DEPTH - 1;

  logic clk = 1'b0;
  logic resetn, start, host_wr_valid;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;

  logic          host_wr_ready [2];
  logic          ram_cea [2], ram_wrea [2], ram_ceb [2], ram_oceb [2];
  logic          playing [2], frame_done [2];
  logic [AW-1:0] ram_ada [2], ram_adb [2];
  logic [DW-1:0] ram_dina [2], ram_doutb [2], led [2];

  always #5 clk = ~clk;

  // Instance 0 uses read latency 1, instance 1 uses read latency 2.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout1, dout2;

    dpb_led_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD), .READ_LAT(g + 1)
    ) u_dut (
      .clk(clk), .resetn(resetn), .start(start),
      .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr),
      .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready[g]),
      .ram_cea(ram_cea[g]), .ram_wrea(ram_wrea[g]), .ram_ada(ram_ada[g]),
      .ram_dina(ram_dina[g]), .ram_ceb(ram_ceb[g]), .ram_oceb(ram_oceb[g]),
      .ram_adb(ram_adb[g]), .ram_doutb(ram_doutb[g]), .led(led[g]),
      .playing(playing[g]), .frame_done(frame_done[g])
    );

    // Dual-port RAM: read-first port B, optional output register.
    always @(posedge clk) begin
      if (ram_cea[g] && ram_wrea[g]) mem[ram_ada[g]] <= ram_dina[g];
      if (ram_ceb[g]) dout1 <= mem[ram_adb[g]];
      if (ram_oceb[g]) dout2 <= dout1;
    end
    assign ram_doutb[g] = (g == 0) ? dout1 : dout2;
  end

  int n_cmp = 0;
  int n_bad = 0;

  int            exp_mem [DEPTH];
  int            rd_val  [64];
  logic [DW-1:0] held    [2];

  task automatic chk(input string tag, input int g, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s (read_lat %0d): observed %0h expected %0h", tag, g + 1, obs, exp);
    end
  endtask

  // n-th word displayed in a playback run, by address.
  function automatic int order(input int n);
`ifdef PLAY_PINGPONG_EN
    int r;
    r = n % (2 * AMAX);
    return (r <= AMAX) ? r : 2 * AMAX - r;
`else
    return n % DEPTH;
`endif
  endfunction

  function automatic bit is_end(input int n);
`ifdef PLAY_PINGPONG_EN
    return (order(n) == AMAX) || (order(n) == 0 && n != 0);
`else
    return order(n) == AMAX;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // nk fill cycles: sequential writes, host blocked, led holding.
  task automatic fill_check(input int nk);
    for (int k = 0; k < nk; k++) begin
      cyc();
      start         = (k == 1);
      host_wr_valid = 1'b1;
      host_wr_addr  = AW'($urandom);
      host_wr_data  = DW'($urandom);
      #1;
      for (int g = 0; g < 2; g++) begin
        chk("fill_cea", g, 32'(ram_cea[g]), 1);
        chk("fill_wrea", g, 32'(ram_wrea[g]), 1);
        chk("fill_ada", g, 32'(ram_ada[g]), 32'(k));
        chk("fill_dina", g, 32'(ram_dina[g]), 32'(k));
        chk("fill_ceb", g, 32'(ram_ceb[g]), 0);
        chk("fill_ready", g, 32'(host_wr_ready[g]), 0);
        chk("fill_playing", g, 32'(playing[g]), 0);
        chk("fill_led", g, 32'(led[g]), 32'(held[g]));
        chk("fill_fdone", g, 32'(frame_done[g]), 0);
      end
      exp_mem[k] = k;
    end
  endtask

  // Playback run of len cycles; optional directed patch or random host
  // writes (never on read cycles); optional start in the last cycle.
  task automatic run_play(input int len, input bit rnd, input bit restart);
    logic [DW-1:0] exp_led;
    int nd;
    bit exp_fd;
    for (int p = 0; p < len; p++) begin
      cyc();
      start         = restart && (p == len - 1);
      host_wr_valid = 1'b0;
      host_wr_addr  = AW'($urandom);
      host_wr_data  = DW'($urandom);
      if (p % TD == 0) begin
        rd_val[p / TD] = exp_mem[order(p / TD)];
      end else if (!start) begin
        if (!rnd && p == 3) begin
          host_wr_valid = 1'b1;
          host_wr_addr  = AW'(2);
          host_wr_data  = 6'h2A;
        end else if (rnd && $urandom_range(0, 2) == 0) begin
          host_wr_valid = 1'b1;
        end
      end
      #1;
      for (int g = 0; g < 2; g++) begin
        chk("play_playing", g, 32'(playing[g]), 1);
        chk("play_ready", g, 32'(host_wr_ready[g]), 1);
        chk("play_ceb", g, 32'(ram_ceb[g]), 32'(p % TD == 0));
        if (p % TD == 0) chk("play_adb", g, 32'(ram_adb[g]), 32'(order(p / TD)));
        chk("host_cea", g, 32'(ram_cea[g]), 32'(host_wr_valid));
        chk("host_wrea", g, 32'(ram_wrea[g]), 32'(host_wr_valid));
        if (host_wr_valid) begin
          chk("host_ada", g, 32'(ram_ada[g]), 32'(host_wr_addr));
          chk("host_dina", g, 32'(ram_dina[g]), 32'(host_wr_data));
        end
        // Word n lands READ_LAT edges after the edge closing its read cycle.
        nd = (p >= 2 + g) ? (p - 2 - g) / TD + 1 : 0;
        exp_led = (nd == 0) ? held[g] : ~DW'(rd_val[nd - 1]);
        exp_fd  = (nd > 0) && ((p - 2 - g) % TD == 0) && is_end(nd - 1);
        chk("led", g, 32'(led[g]), 32'(exp_led));
        chk("frame_done", g, 32'(frame_done[g]), 32'(exp_fd));
        if (p == len - 1) held[g] = exp_led;
      end
      if (host_wr_valid) exp_mem[host_wr_addr] = int'(host_wr_data);
    end
  endtask

  initial begin
    resetn        = 1'b0;
    start         = 1'b0;
    host_wr_valid = 1'b0;
    host_wr_addr  = '0;
    host_wr_data  = '0;
    held[0]       = '1;
    held[1]       = '1;

    // Reset state.
    cyc();
    cyc();
    for (int g = 0; g < 2; g++) begin
      chk("rst_cea", g, 32'(ram_cea[g]), 0);
      chk("rst_ceb", g, 32'(ram_ceb[g]), 0);
      chk("rst_ada", g, 32'(ram_ada[g]), 0);
      chk("rst_adb", g, 32'(ram_adb[g]), 0);
      chk("rst_led", g, 32'(led[g]), 32'h3F);
      chk("rst_playing", g, 32'(playing[g]), 0);
      chk("rst_ready", g, 32'(host_wr_ready[g]), 0);
      chk("rst_oceb", g, 32'(ram_oceb[g]), 1);
    end
    resetn = 1'b1;

    // Start pulse from IDLE, fill, play with a directed patch, restart.
    cyc();
    start = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) chk("idle_cea", g, 32'(ram_cea[g]), 0);
    fill_check(4);
    run_play(66, 1'b0, 1'b1);

    // Refill (led held), randomized host patches, restart again.
    fill_check(4);
    run_play(40, 1'b1, 1'b1);

    // Reset in the middle of a fill.
    fill_check(2);
    cyc();
    start         = 1'b0;
    host_wr_valid = 1'b0;
    resetn        = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) chk("pre_rst_ada", g, 32'(ram_ada[g]), 2);
    cyc();
    for (int g = 0; g < 2; g++) begin
      chk("abort_cea", g, 32'(ram_cea[g]), 0);
      chk("abort_wrea", g, 32'(ram_wrea[g]), 0);
      chk("abort_ceb", g, 32'(ram_ceb[g]), 0);
      chk("abort_led", g, 32'(led[g]), 32'h3F);
      chk("abort_playing", g, 32'(playing[g]), 0);
      chk("abort_fdone", g, 32'(frame_done[g]), 0);
    end
    resetn = 1'b1;

    // IDLE stays put without start and refuses host writes.
    for (int i = 0; i < 3; i++) begin
      cyc();
      host_wr_valid = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
        chk("idle_hold_cea", g, 32'(ram_cea[g]), 0);
        chk("idle_hold_ready", g, 32'(host_wr_ready[g]), 0);
        chk("idle_hold_playing", g, 32'(playing[g]), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
